// File: rtl/ftdi245_fifo_emu.sv
// Cycle-level emulator of the host side of an FT232H async 245 FIFO port.
// The host loads bytes into an RX queue that the FPGA reads with rd_n, and
// drains an FWFT TX queue that the FPGA fills with wr_n. Read latency, txe_n
// back-pressure stalls, sticky protocol-error flags and byte counters are
// provided so link benches can drive packet traffic without ad-hoc waits.
module ftdi245_fifo_emu #(
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16,
  parameter int RD_LATENCY   = 1,
  parameter int STALL_PERIOD = 0,
  parameter int STALL_LEN    = 2
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [7:0]  host_in_data,
  input  logic        host_in_valid,
  output logic        host_in_ready,
  output logic [7:0]  host_out_data,
  output logic        host_out_valid,
  input  logic        host_out_ready,
  output logic        rxf_n,
  output logic        txe_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  adbus_in,
  output logic [7:0]  adbus_out,
  output logic        adbus_oe,
  output logic        rd_err,
  output logic        wr_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DRIVE, R_GAP} rx_state_t;
  typedef enum logic [1:0] {T_READY, T_GAP, T_STALL} tx_state_t;

  // Queue storage (data only, never reset)
  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];

  logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;

  rx_state_t   rx_state_q, rx_state_d;
  tx_state_t   tx_state_q, tx_state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] tx_tmr_q, tx_tmr_d;
  logic [15:0] stall_acc_q, stall_acc_d;

  logic        rd_prev_q, rd_prev_d;
  logic        wr_prev_q, wr_prev_d;
  logic        wr_armed_q, wr_armed_d;
  logic [7:0]  wr_byte_q, wr_byte_d;

  logic        rxf_n_q, rxf_n_d;
  logic        txe_n_q, txe_n_d;
  logic        adbus_oe_q, adbus_oe_d;
  logic [7:0]  adbus_out_q, adbus_out_d;
  logic        rd_err_q, rd_err_d;
  logic        wr_err_q, wr_err_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic        rd_fall, rd_rise, wr_fall, wr_rise;
  logic        rx_full, tx_full, rx_empty_nx, tx_full_nx;
  logic        rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0]  rx_head;
  logic [15:0] stall_acc_nx;

  // Strobe edges are judged against the sample taken on the previous edge
  assign rd_fall = rd_prev_q & ~rd_n;
  assign rd_rise = ~rd_prev_q & rd_n;
  assign wr_fall = wr_prev_q & ~wr_n;
  assign wr_rise = ~wr_prev_q & wr_n;

  assign rx_full = (rx_cnt_q == RX_FULL_CNT);
  assign tx_full = (tx_cnt_q == TX_FULL_CNT);
  assign rx_head = rx_mem[rx_rd_ptr_q];

  // A read completes on the rising rd_n edge of an accepted strobe; a write
  // completes on the rising wr_n edge of an armed strobe. A pop in the same
  // cycle frees the slot, so a full TX queue still accepts that push.
  assign rx_push = host_in_valid & ~rx_full;
  assign rx_pop  = ((rx_state_q == R_LAT) || (rx_state_q == R_DRIVE)) & rd_rise;
  assign tx_pop  = (tx_cnt_q != '0) & host_out_ready;
  assign tx_push = (tx_state_q == T_READY) & wr_armed_q & wr_rise & (~tx_full | tx_pop);

  assign host_in_ready  = ~rx_full;
  assign host_out_valid = (tx_cnt_q != '0);
  assign host_out_data  = tx_mem[tx_rd_ptr_q];
  assign rxf_n          = rxf_n_q;
  assign txe_n          = txe_n_q;
  assign adbus_oe       = adbus_oe_q;
  assign adbus_out      = adbus_out_q;
  assign rd_err         = rd_err_q;
  assign wr_err         = wr_err_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;

  // RX and TX queue pointer/occupancy bookkeeping
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(1);
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + (RX_AW+1)'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - (RX_AW+1)'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(1);
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + (TX_AW+1)'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - (TX_AW+1)'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  assign rx_empty_nx = (rx_cnt_d == '0);
  assign tx_full_nx  = (tx_cnt_d == TX_FULL_CNT);

  // RX read handshake: latency count, bus drive, pop on rd_n rise, 1-cycle gap
  always_comb begin
    rx_state_d  = rx_state_q;
    lat_cnt_d   = lat_cnt_q;
    rxf_n_d     = rxf_n_q;
    adbus_oe_d  = adbus_oe_q;
    adbus_out_d = adbus_out_q;
    rd_count_d  = rd_count_q;
    rd_prev_d   = rd_n;
    rd_err_d    = rd_err_q | (~rd_n & rxf_n_q);
    case (rx_state_q)
      R_IDLE: begin
        rxf_n_d = rx_empty_nx;
        if (rd_fall && !rxf_n_q) begin
          rx_state_d = R_LAT;
          lat_cnt_d  = 3'd1;
          rxf_n_d    = 1'b0;
        end
      end
      R_LAT: begin
        if (rd_rise) begin
          rx_state_d  = R_GAP;
          rd_count_d  = rd_count_q + 16'd1;
          rxf_n_d     = 1'b1;
          adbus_oe_d  = 1'b0;
          adbus_out_d = 8'h00;
        end else if (lat_cnt_q == 3'(RD_LATENCY)) begin
          rx_state_d  = R_DRIVE;
          adbus_oe_d  = 1'b1;
          adbus_out_d = rx_head;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      R_DRIVE: begin
        if (rd_rise) begin
          rx_state_d  = R_GAP;
          rd_count_d  = rd_count_q + 16'd1;
          rxf_n_d     = 1'b1;
          adbus_oe_d  = 1'b0;
          adbus_out_d = 8'h00;
        end else begin
          adbus_out_d = rx_head;
        end
      end
      R_GAP: begin
        rx_state_d = R_IDLE;
        rxf_n_d    = rx_empty_nx;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // TX write handshake: arm on wr_n fall, push on rise, then gap or stall
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_tmr_d     = tx_tmr_q;
    stall_acc_d  = stall_acc_q;
    txe_n_d      = txe_n_q;
    wr_count_d   = wr_count_q;
    wr_prev_d    = wr_n;
    wr_armed_d   = wr_armed_q;
    wr_byte_d    = wr_byte_q;
    wr_err_d     = wr_err_q | (wr_fall & txe_n_q);
    stall_acc_nx = stall_acc_q + 16'd1;
    if (wr_fall && !txe_n_q) begin
      wr_armed_d = 1'b1;
    end else if (wr_rise) begin
      wr_armed_d = 1'b0;
    end
    if (!wr_n && (wr_armed_q || (wr_fall && !txe_n_q))) begin
      wr_byte_d = adbus_in;
    end
    case (tx_state_q)
      T_READY: begin
        txe_n_d = tx_full_nx;
        if (tx_push) begin
          wr_count_d = wr_count_q + 16'd1;
          txe_n_d    = 1'b1;
          tx_tmr_d   = 16'd1;
          if ((STALL_PERIOD != 0) && (stall_acc_nx == 16'(STALL_PERIOD))) begin
            tx_state_d  = T_STALL;
            stall_acc_d = 16'd0;
          end else begin
            tx_state_d  = T_GAP;
            stall_acc_d = stall_acc_nx;
          end
        end
      end
      T_GAP: begin
        tx_state_d = T_READY;
        txe_n_d    = tx_full_nx;
      end
      T_STALL: begin
        if (tx_tmr_q == 16'(STALL_LEN)) begin
          tx_state_d = T_READY;
          txe_n_d    = tx_full_nx;
        end else begin
          tx_tmr_d = tx_tmr_q + 16'd1;
        end
      end
      default: tx_state_d = T_READY;
    endcase
  end

  // Queue storage and write-byte capture; payload only, so no reset
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= host_in_data;
    if (tx_push) tx_mem[tx_wr_ptr_q] <= wr_byte_q;
    wr_byte_q <= wr_byte_d;
  end

  // Control state; reset aborts any transfer immediately (txe_n high one cycle)
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
      rx_state_q  <= R_IDLE;
      tx_state_q  <= T_GAP;
      lat_cnt_q   <= 3'd0;
      tx_tmr_q    <= 16'd0;
      stall_acc_q <= 16'd0;
      rd_prev_q   <= 1'b1;
      wr_prev_q   <= 1'b1;
      wr_armed_q  <= 1'b0;
      rxf_n_q     <= 1'b1;
      txe_n_q     <= 1'b1;
      adbus_oe_q  <= 1'b0;
      adbus_out_q <= 8'h00;
      rd_err_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      rd_count_q  <= 16'd0;
      wr_count_q  <= 16'd0;
    end else begin
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      lat_cnt_q   <= lat_cnt_d;
      tx_tmr_q    <= tx_tmr_d;
      stall_acc_q <= stall_acc_d;
      rd_prev_q   <= rd_prev_d;
      wr_prev_q   <= wr_prev_d;
      wr_armed_q  <= wr_armed_d;
      rxf_n_q     <= rxf_n_d;
      txe_n_q     <= txe_n_d;
      adbus_oe_q  <= adbus_oe_d;
      adbus_out_q <= adbus_out_d;
      rd_err_q    <= rd_err_d;
      wr_err_q    <= wr_err_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

endmodule

// File: doc/ftdi245_fifo_emu.md
Name: ftdi245_fifo_emu

Overview:
Synthesizable emulator of the host-side FT232H async 245 FIFO interface: rxf_n/txe_n flags, rd_n/wr_n strobes, 8-bit ADBUS data. It is the parametrised successor to the hand-written FTDI stimulus used in link benches. Sits between a bench or loopback harness and a Laser ChipInterface, so START/STOP/ACK/DONE packet traffic can be driven at cycle level without ad-hoc waits. Adds configurable buffer depths, read latency, txe back-pressure, protocol-error detection and byte counters.

Parameters:
RX_DEPTH, 16, host->FPGA byte queue depth (power of 2, >=2)
TX_DEPTH, 16, FPGA->host byte queue depth (power of 2, >=2)
RD_LATENCY, 1, cycles from rd_n sampled low to adbus_oe/data valid (1..7)
STALL_PERIOD, 0, force txe_n high after every N accepted writes; 0 = never
STALL_LEN, 2, cycles txe_n is held high per stall (>=1)

Ports:
clock  in  1  system clock
resetN  in  1  asynchronous active-low reset
host_in_data  in  8  byte for the FPGA to read
host_in_valid  in  1  host_in_data valid
host_in_ready  out  1  RX queue not full
host_out_data  out  8  byte written by the FPGA
host_out_valid  out  1  TX queue not empty
host_out_ready  in  1  consumer accepts host_out_data
rxf_n  out  1  low = byte available to FPGA
txe_n  out  1  low = FPGA may write
rd_n  in  1  FPGA read strobe, active low
wr_n  in  1  FPGA write strobe, active low
adbus_in  in  8  data driven by FPGA during writes
adbus_out  out  8  data driven toward FPGA
adbus_oe  out  1  adbus_out drive enable
rd_err  out  1  sticky: rd_n low while rxf_n high
wr_err  out  1  sticky: wr_n falling while txe_n high
rd_count  out  16  bytes read by FPGA, wraps at 2^16
wr_count  out  16  bytes written by FPGA, wraps at 2^16

Behaviour:
- All strobes sampled on clock rising edge; rd_n/wr_n are synchronous to clock. Edges detected against the previous sample.
- Reset: queues empty, rxf_n=1, txe_n=1 for one cycle then 0, adbus_oe=0, adbus_out=0, host_in_ready=1, host_out_valid=0, errors=0, counters=0, stall counter=0.
- Host load: host_in_valid&&host_in_ready pushes a byte. Host drain: host_out_valid&&host_out_ready pops host_out_data, which is the head of the TX queue (FWFT).
- RX FSM: R_IDLE/R_LAT/R_DRIVE/R_GAP.
  - R_IDLE: rxf_n = queue empty.
  - Fall of rd_n with rxf_n=0 enters R_LAT. Count RD_LATENCY cycles, then R_DRIVE with adbus_oe=1, adbus_out=head.
  - Rise of rd_n in R_LAT or R_DRIVE pops the head, increments rd_count, drops adbus_oe the same edge, enters R_GAP. rxf_n=1 for exactly 1 cycle, then R_IDLE.
  - rd_n low while rxf_n=1: set rd_err; no pop; adbus_oe stays 0.
- Simultaneous push on an empty RX queue and rd_n fall: rxf_n is still 1 that cycle, so the read is an error.
- Push during R_LAT/R_DRIVE is allowed.
- TX FSM: T_READY/T_GAP/T_STALL.
  - T_READY: txe_n = TX queue full.
  - Fall of wr_n with txe_n=0 arms capture. The rise of wr_n pushes adbus_in sampled on the last low cycle and increments wr_count.
  - After the push: if STALL_PERIOD!=0 and accepted writes mod STALL_PERIOD == 0, enter T_STALL (txe_n=1 for STALL_LEN cycles). Otherwise T_GAP (txe_n=1 for 1 cycle). Then T_READY.
  - wr_n fall while txe_n=1: set wr_err, byte discarded.
- Simultaneous pop on a full TX queue and wr_n rise: the push succeeds.
- Counters wrap 0xFFFF->0x0000. Error flags clear only on reset.
- resetN assertion mid-transfer aborts immediately: adbus_oe=0, partial byte not counted.

Test Plan:
- Reset, then push 0xA5 (START_SEQ-like) and 0x01 -> rxf_n low 1 cycle after push; rd_n pulse 3 cycles -> adbus_out=0xA5 valid RD_LATENCY cycles after fall; rd_count=1; rxf_n high 1 cycle, then low; second read returns 0x01; rxf_n stays high.
- FPGA writes 0x10,0x11,0x12 with STALL_PERIOD=2, STALL_LEN=3 -> txe_n high 1 cycle after the 1st write and 3 cycles after the 2nd; host_out_data sequence 0x10,0x11,0x12; wr_count=3.
- TX_DEPTH=4, host_out_ready=0, 4 writes -> txe_n stays 1, 5th wr_n pulse sets wr_err, queue unchanged. Drain one byte -> txe_n=0 next cycle.
- rd_n pulsed with RX queue empty -> rd_err=1, adbus_oe never asserted, rd_count=0.
- resetN pulsed low during R_DRIVE -> adbus_oe=0 asynchronously, rxf_n=1, counters 0, queues empty.
- Loop 65537 bytes through RX -> rd_count=0x0001, no errors, order preserved.
